// File: rtl/anita4_trigger_scaler_bank.sv
// Trigger scaler bank: eight saturating rate counters gated by a programmable
// period, with holding registers latched at each gate end and a simple
// select/strobe read port.

// One scaler channel: live counter, live saturation flag, and the holding
// register plus saturation flag presented to software.
module anita4_scaler_lane #(
    parameter int WIDTH = 16
) (
    input  logic             mclk_i,
    input  logic             rst_n_i,
    input  logic             ev_i,
    input  logic             restart_i,
    input  logic             close_i,
    output logic [WIDTH-1:0] hold_o,
    output logic             sat_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d, hold_q, hold_d, next_cnt;
    logic             lsat_q, lsat_d, sat_q, sat_d, full, ovf;

    // Saturating count; at gate close the terminal-cycle event is folded into
    // the value that gets latched, and the live state restarts from zero.
    always_comb begin
        full     = &cnt_q;
        ovf      = ev_i & full;
        next_cnt = (ev_i && !full) ? cnt_q + WIDTH'(1) : cnt_q;
        cnt_d    = cnt_q;
        lsat_d   = lsat_q;
        hold_d   = hold_q;
        sat_d    = sat_q;
        if (restart_i) begin
            cnt_d  = '0;
            lsat_d = 1'b0;
        end else if (close_i) begin
            hold_d = next_cnt;
            sat_d  = lsat_q | ovf;
            cnt_d  = '0;
            lsat_d = 1'b0;
        end else begin
            cnt_d  = next_cnt;
            lsat_d = lsat_q | ovf;
        end
    end

    // Channel state registers
    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            lsat_q <= 1'b0;
            hold_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lsat_q <= lsat_d;
            hold_q <= hold_d;
            sat_q  <= sat_d;
        end
    end

    assign hold_o = hold_q;
    assign sat_o  = sat_q;
endmodule

module anita4_trigger_scaler_bank #(
    parameter int WIDTH    = 16,
    parameter int PERIOD_W = 24
) (
    input  logic                mclk_i,
    input  logic                rst_n_i,
    input  logic [5:0]          l1_scaler_i,
    input  logic [1:0]          l2_scaler_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                clear_i,
    input  logic [2:0]          sel_i,
    input  logic                rd_i,
    output logic [WIDTH-1:0]    dat_o,
    output logic                ack_o,
    output logic                update_o,
    output logic [7:0]          sat_o
);
    localparam int NCH = 8;

    logic [NCH-1:0]            ch;
    logic [NCH-1:0][WIDTH-1:0] hold;
    logic [NCH-1:0]            sat;
    logic [PERIOD_W-1:0]       pcnt_q, pcnt_d;
    logic                      enabled, restart, term;
    logic                      update_q, update_d, ack_q, ack_d;
    logic [WIDTH-1:0]          dat_q, dat_d;

    assign ch = {l2_scaler_i, l1_scaler_i};

    // Gate timing: a zero period parks everything; clear beats a coincident
    // terminal cycle. The >= compare closes the gate at once if the period
    // shrinks below the elapsed count.
    always_comb begin
        enabled  = (period_i != '0);
        restart  = clear_i | ~enabled;
        term     = ~restart & (pcnt_q >= period_i - PERIOD_W'(1));
        pcnt_d   = (restart || term) ? '0 : pcnt_q + PERIOD_W'(1);
        update_d = term;
    end

    // Read port: data reflects the holding value before the sampling edge
    always_comb begin
        ack_d = rd_i;
        dat_d = rd_i ? hold[sel_i] : dat_q;
    end

    // Gate counter, update pulse and read-port registers
    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pcnt_q   <= '0;
            update_q <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            pcnt_q   <= pcnt_d;
            update_q <= update_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        anita4_scaler_lane #(.WIDTH(WIDTH)) u_lane (
            .mclk_i   (mclk_i),
            .rst_n_i  (rst_n_i),
            .ev_i     (ch[k]),
            .restart_i(restart),
            .close_i  (term),
            .hold_o   (hold[k]),
            .sat_o    (sat[k])
        );
    end

    assign dat_o    = dat_q;
    assign ack_o    = ack_q;
    assign update_o = update_q;
    assign sat_o    = sat;
endmodule

// File: tb/tb_anita4_trigger_scaler_bank.sv
// Scoreboard bench for the trigger scaler bank (4-bit counters so that
// saturation is reachable within short gates).
module tb_anita4_trigger_scaler_bank;
    localparam int W = 4;
    localparam int PW = 24;
    localparam int unsigned FULL = (1 << W) - 1;

    logic          mclk, rst_n;
    logic [5:0]    l1;
    logic [1:0]    l2;
    logic [PW-1:0] period;
    logic          clear, rd;
    logic [2:0]    sel;
    logic [W-1:0]  dat;
    logic          ack, upd;
    logic [7:0]    sat;

    anita4_trigger_scaler_bank #(.WIDTH(W), .PERIOD_W(PW)) dut (
        .mclk_i(mclk), .rst_n_i(rst_n), .l1_scaler_i(l1), .l2_scaler_i(l2),
        .period_i(period), .clear_i(clear), .sel_i(sel), .rd_i(rd),
        .dat_o(dat), .ack_o(ack), .update_o(upd), .sat_o(sat)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int nvec = 0;
    int nfail = 0;
    int unsigned cyc = 0;
    int upd_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Events per channel are tallied as plain integers over the gate; the
    // reported value is the tally clipped to full scale, flagged saturated
    // when the tally exceeded it.
    typedef struct {
        int unsigned cyc;
        int unsigned dat;
    } rd_t;
    rd_t         rd_q[$];
    int unsigned upd_q[$];
    int unsigned ev[8];
    int unsigned m_hold[8];
    logic [7:0]  m_sat;
    int unsigned elapsed;
    logic [7:0]  chv;

    initial begin
        elapsed = 0;
        m_sat   = '0;
        for (int k = 0; k < 8; k++) begin
            ev[k] = 0;
            m_hold[k] = 0;
        end
        forever begin
            @(posedge mclk);
            chv = {l2, l1};
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) begin
                    ev[k] = 0;
                    m_hold[k] = 0;
                end
                m_sat   = '0;
                elapsed = 0;
                rd_q.delete();
                upd_q.delete();
            end else begin
                if (rd) rd_q.push_back('{cyc + 1, m_hold[sel]});
                if (period == 0 || clear) begin
                    for (int k = 0; k < 8; k++) ev[k] = 0;
                    elapsed = 0;
                end else begin
                    for (int k = 0; k < 8; k++) ev[k] += chv[k];
                    elapsed++;
                    if (elapsed >= period) begin
                        for (int k = 0; k < 8; k++) begin
                            m_hold[k] = (ev[k] > FULL) ? FULL : ev[k];
                            m_sat[k]  = (ev[k] > FULL);
                            ev[k] = 0;
                        end
                        elapsed = 0;
                        upd_q.push_back(cyc + 1);
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int unsigned exp_dat;
        logic        exp_upd, exp_ack;
        rd_t         r;
        exp_dat = 0;
        forever begin
            @(negedge mclk);
            if (!rst_n) begin
                exp_dat = 0;
            end else begin
                exp_upd = 1'b0;
                if (upd_q.size() > 0 && upd_q[0] <= cyc) begin
                    void'(upd_q.pop_front());
                    exp_upd = 1'b1;
                end
                chk("update_o", upd, exp_upd);
                if (upd) upd_seen++;
                chk("sat_o", sat, m_sat);
                exp_ack = 1'b0;
                if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                    r = rd_q.pop_front();
                    exp_ack = 1'b1;
                    exp_dat = r.dat;
                end
                chk("ack_o", ack, exp_ack);
                chk("dat_o", dat, exp_dat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_upd(input int budget, output int n);
        n = 0;
        while (!upd && n < budget) begin
            @(negedge mclk);
            n++;
        end
        if (!upd) chk("update_timeout", upd, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        rst_n = 1'b0; l1 = 6'b000001; l2 = '0; period = 24'd10;
        clear = 1'b0; rd = 1'b0; sel = '0;
        repeat (3) @(negedge mclk);
        chk("reset_dat", dat, 0);
        chk("reset_ack", ack, 0);
        chk("reset_update", upd, 0);
        chk("reset_sat", sat, 0);
        rst_n = 1'b1;

        // ch0 held high, period 10
        wait_upd(30, n);
        chk("first_update_latency", n, 10);
        for (int i = 0; i < 2; i++) begin
            @(negedge mclk);
            wait_upd(30, n);
            chk("update_spacing", n + 1, 10);
        end
        rd = 1'b1; sel = 3'd0;
        @(negedge mclk);
        rd = 1'b0; l1 = '0;
        chk("t1_ack", ack, 1);
        chk("t1_dat", dat, 10);
        chk("t1_sat", sat, 0);

        // saturation on ch7, period 32
        period = 24'd32; clear = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge mclk);
            clear = 1'b0;
            l2 = (i < 20) ? 2'b10 : 2'b00;
        end
        @(negedge mclk);
        l2 = '0;
        chk("t2_update", upd, 1);
        chk("t2_sat7", sat[7], 1);
        rd = 1'b1; sel = 3'd7; clear = 1'b1;
        @(negedge mclk);
        rd = 1'b0;
        chk("t2_dat_sat", dat, 15);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge mclk);
            clear = 1'b0;
            l2 = (i == 3 || i == 9 || i == 30) ? 2'b10 : 2'b00;
        end
        @(negedge mclk);
        l2 = '0;
        chk("t2b_update", upd, 1);
        chk("t2b_sat7", sat[7], 0);
        rd = 1'b1; sel = 3'd7;
        @(negedge mclk);
        rd = 1'b0;
        chk("t2b_dat", dat, 3);

        // period 8, read on terminal cycle
        period = 24'd8; clear = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge mclk);
            clear = 1'b0;
            l1 = (i < 5) ? 6'b001000 : 6'b0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge mclk);
            l1 = (i == 2 || i == 7) ? 6'b001000 : 6'b0;
            if (i == 7) begin rd = 1'b1; sel = 3'd3; end
        end
        @(negedge mclk);
        l1 = '0;
        chk("t3_update", upd, 1);
        chk("t3_ack_on_T", ack, 1);
        chk("t3_dat_on_T", dat, 5);
        @(negedge mclk);
        rd = 1'b0;
        chk("t3_ack_after", ack, 1);
        chk("t3_dat_after", dat, 2);

        // clear mid-gate discards the gate
        period = 24'd100; clear = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge mclk);
            clear = 1'b0;
            l1 = (i < 40) ? 6'b000010 : 6'b0;
        end
        @(negedge mclk);
        l1 = '0; clear = 1'b1;
        base = upd_seen;
        n = 0;
        while (n < 200) begin
            @(negedge mclk);
            n++;
            if (upd) break;
            clear = 1'b0;
            l1 = (n <= 7) ? 6'b000010 : 6'b0;
        end
        l1 = '0;
        // clear edge plus 100 gate cycles
        chk("t4_update_after_clear", n, 101);
        chk("t4_single_update", upd_seen - base, 1);
        rd = 1'b1; sel = 3'd1;
        @(negedge mclk);
        rd = 1'b0;
        chk("t4_dat", dat, 7);

        // period shrink mid-gate, then disabled
        period = 24'd100; clear = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge mclk);
            clear = 1'b0;
            l1 = 6'($urandom);
        end
        @(negedge mclk);
        period = 24'd20;
        @(negedge mclk);
        chk("t5_shrink_update", upd, 1);
        period = '0;
        @(negedge mclk);
        base = upd_seen;
        for (int i = 0; i < 1000; i++) begin
            @(negedge mclk);
            l1 = 6'($urandom); l2 = 2'($urandom);
            rd = ($urandom_range(0, 3) == 0); sel = 3'($urandom);
        end
        @(negedge mclk);
        rd = 1'b0;
        chk("t5_disabled_no_update", upd_seen - base, 0);

        // randomized traffic
        period = 24'd12;
        for (int i = 0; i < 3000; i++) begin
            @(negedge mclk);
            l1 = 6'($urandom); l2 = 2'($urandom);
            clear = ($urandom_range(0, 63) == 0);
            rd = ($urandom_range(0, 3) == 0); sel = 3'($urandom);
            if ($urandom_range(0, 199) == 0)
                period = ($urandom_range(0, 9) == 0) ? '0 : 24'($urandom_range(1, 40));
        end

        // asynchronous reset mid-gate
        @(negedge mclk);
        clear = 1'b1; rd = 1'b0; period = 24'd30; l1 = '1; l2 = '1;
        for (int i = 0; i < 30; i++) begin
            @(negedge mclk);
            clear = 1'b0;
        end
        @(negedge mclk);
        chk("t6_sat_all", sat, 8'hff);
        rd = 1'b1; sel = 3'd2;
        @(negedge mclk);
        rd = 1'b0;
        chk("t6_dat", dat, 15);
        repeat (10) @(negedge mclk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dat", dat, 0);
        chk("async_rst_sat", sat, 0);
        chk("async_rst_ack", ack, 0);
        chk("async_rst_update", upd, 0);
        l1 = '0; l2 = '0;
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        wait_upd(60, n);
        chk("post_reset_latency", n, 30);
        rd = 1'b1; sel = 3'd2;
        @(negedge mclk);
        rd = 1'b0;
        chk("post_reset_dat", dat, 0);
        repeat (3) @(negedge mclk);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/anita4_trigger_scaler_bank.md
Name: anita4_trigger_scaler_bank

Overview:
Rate-counter bank downstream of the dual-phi L1/L2 trigger stage. It consumes the six L1 scaler flags and two L2 scaler flags, which arrive already synchronized into the management clock domain as single-cycle pulses. It counts them over a programmable gate period and latches the totals into holding registers at each period end. Software reads the totals through a simple select/read-strobe port with a one-cycle acknowledge.

Parameters:
WIDTH, 16, width of each per-channel counter and holding register (saturating)
PERIOD_W, 24, width of the gate-period counter and period_i

Ports:
mclk_i  input  1  management clock; all logic on rising edge
rst_n_i  input  1  asynchronous active-low reset
l1_scaler_i  input  6  L1 flag pulses, bit order {top0,mid0,bot0,top1,mid1,bot1}; counted as channels 5..0
l2_scaler_i  input  2  L2 flag pulses, phi1/phi0; counted as channels 7/6
period_i  input  PERIOD_W  gate length in mclk_i cycles; 0 = disabled
clear_i  input  1  synchronous restart of the current gate
sel_i  input  3  channel select for read
rd_i  input  1  read strobe, one cycle
dat_o  output  WIDTH  read data
ack_o  output  1  read acknowledge pulse
update_o  output  1  one-cycle pulse: holding registers just updated
sat_o  output  8  per-channel saturation flag of the current holding values

Behaviour:
- Reset (rst_n_i low, asynchronous): all counters, holding registers, period counter, dat_o, ack_o, update_o and sat_o are 0.
- Channel vector ch[7:0] = {l2_scaler_i, l1_scaler_i}. Each high cycle counts as one event. Inputs are not edge-detected: a flag held high N cycles counts N.
- Live counter cnt[k]:
  - increments by 1 on each cycle ch[k]=1;
  - saturates at 2^WIDTH-1 and never wraps;
  - live sat bit lsat[k] sets when an increment is attempted at full scale.
- Period counter pcnt increments every cycle while period_i != 0.
- Terminal cycle T: pcnt >= period_i-1. The >= compare handles period_i shrinking mid-gate. At the edge ending T:
  - hold[k] <= saturating(cnt[k] + ch[k]), so the event on the terminal cycle lands in the closing gate;
  - sat_o[k] <= lsat[k], or 1 if that final add saturates;
  - cnt, lsat, pcnt <= 0;
  - update_o = 1 for exactly the following cycle.
- period_i = 0: pcnt, cnt and lsat are held at 0; no updates occur; hold and sat_o retain their values.
- clear_i = 1: cnt, lsat, pcnt <= 0; hold and sat_o are retained; no update_o. clear_i has priority over a coincident terminal cycle, and that gate is discarded.
- Read:
  - rd_i sampled high -> next cycle ack_o = 1 and dat_o = hold[sel_i] as it was before that edge. A read coincident with T therefore returns the previous gate.
  - Back-to-back reads each get their own ack in consecutive cycles.
  - dat_o holds its value between reads.
- Latency: an event appears in hold one edge after the T cycle of its gate. update_o is asserted in the same cycle as the new hold/sat_o values.

Test Plan:
- period_i=10, ch0 held high from reset release, then rd_i with sel_i=0 after update_o -> update_o pulses every 10 cycles; ack_o next cycle with dat_o=10, sat_o=0.
- WIDTH=4, period_i=32, ch7 high for 20 cycles of the gate -> hold[7]=15, sat_o[7]=1. Next gate with 3 pulses -> hold[7]=3, sat_o[7]=0.
- period_i=8: 5 pulses on ch3 in the first gate, 2 pulses in the second including one on T; rd_i sel=3 exactly on the second T -> dat_o=5; a read one cycle later -> dat_o=2.
- period_i=100, 40 ch1 pulses, clear_i at cycle 50, then 7 pulses -> first update_o 100 cycles after clear with hold[1]=7; no update_o at the original cycle-100 boundary.
- period_i switched from 100 to 20 when pcnt=50 -> terminal on the next cycle and update_o pulses. period_i=0 -> no update_o for 1000 cycles and hold unchanged.
- rst_n_i asserted mid-gate with nonzero counts -> all outputs 0 immediately, before any clock edge. After release the first update_o occurs period_i cycles later.
